// File: rtl/seq_lab_pkg.sv
// Shared definitions for the lab vector sequencer: state encoding, observed
// output width and the bit layout of one vector-table entry.
package seq_lab_pkg;

    // Width of the lab circuit's observed outputs {X,Y,Z,R,S}.
    localparam int OW = 5;

    // One table entry is {c, a, b, exp[OW-1:0]}.
    localparam int ENT_W       = 3 + OW;
    localparam int ENT_C       = OW + 2;
    localparam int ENT_A       = OW + 1;
    localparam int ENT_B       = OW;
    localparam int ENT_EXP_LSB = 0;

    // Sequencer states.
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_APPLY  = 3'd1,
        S_SETTLE = 3'd2,
        S_SAMPLE = 3'd3,
        S_DONE   = 3'd4
    } state_e;

endpackage

// File: rtl/seq_vec_table.sv
// Vector table: DEPTH x W register file, one synchronous write port and one
// asynchronous read port. Contents are not reset.
module seq_vec_table #(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int W     = 8
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [W-1:0]  wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [W-1:0]  rd_data
);

    logic [W-1:0] mem_q [DEPTH];

    // Store an entry on a write strobe.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/seq_vector_sequencer.sv
// Vector sequencer: steps through a loaded table, drives {CLK,A,B} of the lab
// circuit, waits SETTLE cycles, then compares its {X,Y,Z,R,S} outputs against
// the expected value stored with the vector. OW must match seq_lab_pkg::OW,
// since the entry layout comes from the package.
module seq_vector_sequencer #(
    parameter int DEPTH  = 16,
    parameter int AW     = 4,
    parameter int SETTLE = 2,
    parameter int OW     = seq_lab_pkg::OW
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            wr_en,
    input  logic [AW-1:0]   wr_addr,
    input  logic [OW+2:0]   wr_data,
    input  logic [AW:0]     len,
    input  logic            start,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [AW:0]     err_cnt,
    output logic [AW-1:0]   fail_idx,
    output logic            dut_clk,
    output logic            dut_a,
    output logic            dut_b,
    input  logic [OW-1:0]   dut_obs
);

    import seq_lab_pkg::*;

    localparam int            CW          = $clog2(SETTLE + 1);
    localparam logic [AW:0]   DEPTH_L     = (AW+1)'(DEPTH);
    localparam logic [AW:0]   LEN_ZERO    = {(AW+1){1'b0}};
    localparam logic [AW:0]   ERR_MAX     = {(AW+1){1'b1}};
    localparam logic [CW-1:0] SETTLE_INIT = CW'(SETTLE - 1);

    state_e          state_q, state_d;
    logic [AW-1:0]   idx_q, idx_d;
    logic [AW-1:0]   last_q, last_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            pass_q, pass_d;
    logic [AW:0]     err_q, err_d;
    logic [AW-1:0]   fidx_q, fidx_d;
    logic [2:0]      drv_q, drv_d;

    logic [OW+2:0]   ent_s;
    logic [AW:0]     len_eff_s;
    logic            tbl_we_s;
    logic            mismatch_s;

    // The table is only writable while no run is in progress.
    assign tbl_we_s = wr_en & ~busy_q;

    seq_vec_table #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .W     (OW + 3)
    ) u_table (
        .clk     (CLK),
        .wr_en   (tbl_we_s),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (idx_q),
        .rd_data (ent_s)
    );

    // Clamp the requested length to the table size and compare the sample.
    always_comb begin
        if (len > DEPTH_L) begin
            len_eff_s = DEPTH_L;
        end else begin
            len_eff_s = len;
        end
        mismatch_s = (dut_obs != ent_s[ENT_EXP_LSB +: OW]);
    end

    // Next-state, counters, result accumulation and registered-output values.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        pass_d  = pass_q;
        err_d   = err_q;
        fidx_d  = fidx_q;
        drv_d   = drv_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    // A zero-length run has no mismatches, so results clear too.
                    idx_d  = {AW{1'b0}};
                    err_d  = LEN_ZERO;
                    fidx_d = {AW{1'b0}};
                    pass_d = 1'b1;
                    last_d = AW'(len_eff_s - (AW+1)'(1));
                    if (len == LEN_ZERO) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_APPLY;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_APPLY: begin
                drv_d   = {ent_s[ENT_C], ent_s[ENT_A], ent_s[ENT_B]};
                cnt_d   = SETTLE_INIT;
                state_d = S_SETTLE;
            end
            S_SETTLE: begin
                if (cnt_q == {CW{1'b0}}) begin
                    state_d = S_SAMPLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_SAMPLE: begin
                if (mismatch_s) begin
                    if (err_q != ERR_MAX) begin
                        err_d = err_q + (AW+1)'(1);
                    end else begin
                        err_d = err_q;
                    end
                    // pass is still high only until the first mismatch of the run.
                    if (pass_q) begin
                        fidx_d = idx_q;
                        pass_d = 1'b0;
                    end else begin
                        fidx_d = fidx_q;
                    end
                end else begin
                    err_d = err_q;
                end
                if (idx_q == last_q) begin
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + AW'(1);
                    state_d = S_APPLY;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d == S_APPLY) || (state_d == S_SETTLE) || (state_d == S_SAMPLE);
        done_d = (state_d == S_DONE);
    end

    // State and output registers; reset aborts any run and clears the drives.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= S_IDLE;
            idx_q   <= {AW{1'b0}};
            last_q  <= {AW{1'b0}};
            cnt_q   <= {CW{1'b0}};
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b1;
            err_q   <= LEN_ZERO;
            fidx_q  <= {AW{1'b0}};
            drv_q   <= 3'b000;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            err_q   <= err_d;
            fidx_q  <= fidx_d;
            drv_q   <= drv_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign pass     = pass_q;
    assign err_cnt  = err_q;
    assign fail_idx = fidx_q;
    assign dut_clk  = drv_q[2];
    assign dut_a    = drv_q[1];
    assign dut_b    = drv_q[0];

endmodule
